// File: rtl/funit_seq_pkg.sv
// Shared constants for the funit pass sequencer: state encodings and function-select codes.
package funit_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int FS_MF_BIT = 4;

  localparam logic [4:0] FS_PASS = 5'h00;
  localparam logic [4:0] FS_ADD  = 5'h02;
  localparam logic [4:0] FS_SUB  = 5'h05;
  localparam logic [4:0] FS_SHL  = 5'h10;
  localparam logic [4:0] FS_SHR  = 5'h11;

  function automatic logic is_shift(input logic [4:0] fs);
    return fs[FS_MF_BIT];
  endfunction

endpackage

// File: rtl/funit_seq.sv
// Multi-pass sequencer: replays one command through an external funit 1..N times,
// feeding fout back into opA (ALU) or opB (shifter), then returns the final result.
module funit_seq
  import funit_seq_pkg::*;
#(
  parameter int BW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_fs,
  input  logic [BW-1:0] cmd_a,
  input  logic [BW-1:0] cmd_b,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          cmd_wpsw,
  output logic [BW-1:0] fu_opA,
  output logic [BW-1:0] fu_opB,
  output logic [4:0]    fu_fs,
  output logic          fu_rw,
  input  logic [BW-1:0] fu_fout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_data,
  output logic          busy
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [4:0]    fs_reg;
  logic          wpsw_reg;
  logic [CW-1:0] rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fu_opA   <= '0;
      fu_opB   <= '0;
      fs_reg   <= '0;
      wpsw_reg <= 1'b0;
      rem      <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            fu_opA   <= cmd_a;
            fu_opB   <= cmd_b;
            fs_reg   <= cmd_fs;
            wpsw_reg <= cmd_wpsw;
            rem      <= (cmd_cnt == '0) ? ONE : cmd_cnt;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Intermediate passes recirculate fout; only the last pass produces the response.
          if (rem > ONE) begin
            if (is_shift(fs_reg)) fu_opB <= fu_fout;
            else                  fu_opA <= fu_fout;
            rem <= rem - ONE;
          end else begin
            rsp_data <= fu_fout;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PSW write comes purely from registered state so it is steady across the funit's negedge latch.
  assign fu_fs     = (state == S_EXEC) ? fs_reg : 5'd0;
  assign fu_rw     = (state == S_EXEC) && wpsw_reg && (rem == ONE);
  assign cmd_ready = rst && (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_funit_seq.sv
// Bench for funit_seq with a behavioural funit (ALU, 1-bit shifter, 2-bit PSW) and a result scoreboard.
module tb_funit_seq;
  import funit_seq_pkg::*;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_fs;
  logic [BW-1:0] cmd_a;
  logic [BW-1:0] cmd_b;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_wpsw;
  logic [BW-1:0] fu_opA;
  logic [BW-1:0] fu_opB;
  logic [4:0]    fu_fs;
  logic          fu_rw;
  logic [BW-1:0] fu_fout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_data;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] sb[$];

  funit_seq #(.BW(BW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fs(cmd_fs),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt), .cmd_wpsw(cmd_wpsw),
    .fu_opA(fu_opA), .fu_opB(fu_opB), .fu_fs(fu_fs), .fu_rw(fu_rw),
    .fu_fout(fu_fout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW:0] fu_eval(input logic [4:0] fs, input logic [BW-1:0] a,
                                          input logic [BW-1:0] b);
    logic [BW:0] r;
    r = '0;
    case (fs)
      FS_SHL:  r = {1'b0, b << 1};
      FS_SHR:  r = {1'b0, b >> 1};
      FS_ADD:  r = {1'b0, a} + {1'b0, b};
      FS_SUB:  r = {1'b0, a - b};
      default: r = fs[4] ? {1'b0, b} : {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic logic [BW-1:0] model(input logic [4:0] fs, input logic [BW-1:0] a,
                                          input logic [BW-1:0] b, input logic [CW-1:0] cnt);
    int n;
    logic [BW:0] r;
    n = (cnt == 0) ? 1 : int'(cnt);
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = fu_eval(fs, a, b);
      if (fs[4]) b = r[BW-1:0];
      else       a = r[BW-1:0];
    end
    return r[BW-1:0];
  endfunction

  logic [BW:0] fu_res;
  logic [1:0]  psw = 2'b00;
  always_comb fu_res = fu_eval(fu_fs, fu_opA, fu_opB);
  assign fu_fout = fu_res[BW-1:0];
  always @(negedge clk) if (fu_rw) psw <= {fu_res[BW], fu_res[BW-1:0] == '0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check latency and PSW-write timing, compare result, then release after 'hold' stalled cycles.
  task automatic run_cmd(input string tag, input logic [4:0] fs, input logic [BW-1:0] a,
                         input logic [BW-1:0] b, input logic [CW-1:0] cnt,
                         input logic wpsw, input int hold);
    int n, rw_cnt, rw_pos, exp_n;
    logic done;
    logic [BW-1:0] exp_d;
    exp_n = (cnt == 0) ? 1 : int'(cnt);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_fs = fs; cmd_a = a; cmd_b = b; cmd_cnt = cnt; cmd_wpsw = wpsw;
    sb.push_back(model(fs, a, b, cnt));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; rw_cnt = 0; rw_pos = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rsp_valid) done = 1'b1;
      else begin
        n++;
        if (fu_rw) begin rw_cnt++; rw_pos = n; end
        if (n > 40) done = 1'b1;
      end
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_rwcnt"}, 32'(rw_cnt), wpsw ? 32'd1 : 32'd0);
    chk({tag, "_rwpos"}, 32'(rw_pos), wpsw ? 32'(exp_n) : 32'd0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_fs = FS_ADD; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_cnt = 4'd2;
      @(negedge clk);
      chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_d"}, 32'(rsp_data), 32'(exp_d));
      chk({tag, "_hold_rdy"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_rvlow"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_fs = '0; cmd_a = '0; cmd_b = '0;
    cmd_cnt = '0; cmd_wpsw = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {fu_opA, fu_opB, 3'b0, fu_fs, 7'b0, fu_rw}, 32'd0);
    chk("rst_rsp", {23'b0, rsp_valid, rsp_data}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    run_cmd("shl3", FS_SHL, 8'h00, 8'h01, 4'd3, 1'b0, 0);
    chk("shl3_exact", 32'(model(FS_SHL, 8'h00, 8'h01, 4'd3)), 32'h08);
    run_cmd("add4", FS_ADD, 8'h05, 8'h03, 4'd4, 1'b1, 0);
    chk("add4_psw", 32'(psw), 32'h0);
    run_cmd("cnt0", FS_ADD, 8'h01, 8'h01, 4'd0, 1'b0, 0);
    run_cmd("pswset", FS_ADD, 8'hFF, 8'h01, 4'd1, 1'b1, 0);
    chk("pswset_psw", 32'(psw), 32'h3);
    run_cmd("nowpsw", FS_ADD, 8'hF0, 8'h10, 4'd3, 1'b0, 0);
    chk("nowpsw_psw", 32'(psw), 32'h3);
    run_cmd("bp", FS_SUB, 8'h40, 8'h03, 4'd2, 1'b0, 5);
    run_cmd("shr", FS_SHR, 8'h00, 8'h80, 4'd7, 1'b0, 0);

    // Reset in the middle of a long command aborts it with no response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_fs = FS_ADD; cmd_a = 8'h01; cmd_b = 8'h01; cmd_cnt = 4'd15; cmd_wpsw = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rw", 32'(fu_rw), 32'd0);
    chk("mid_outs", {fu_opA, fu_opB, 3'b0, fu_fs, 8'b0}, 32'd0);
    chk("mid_rsp", {22'b0, busy, rsp_valid, rsp_data}, 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd0);
    chk("mid_psw", 32'(psw), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rel_rv", 32'(rsp_valid), 32'd0);
    run_cmd("post", FS_ADD, 8'h10, 8'h20, 4'd2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
